// File: rtl/apb_reg_pkg.sv
// Shared types and limits for the APB register bank.
// Limits bound the wait counter width and register count.
package apb_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int MAX_WAIT_CYCLES = 15;
   localparam int MAX_NUM_REGS    = 64;
   localparam int CNT_W = $clog2(MAX_WAIT_CYCLES + 1);

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_reg_bank_if.sv
// APB completer-side bus bundle for apb_reg_bank.
// pstrb exists only when APB_REG_BANK_PSTRB_EN is defined.
interface apb_reg_bank_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
`ifdef APB_REG_BANK_PSTRB_EN
   logic [DATA_W/8-1:0] pstrb;
`endif
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

`ifdef APB_REG_BANK_PSTRB_EN
   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );
   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
`else
   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );
   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
`endif
endinterface

// File: rtl/apb_reg_decode.sv
// Byte address to register index, flagging misaligned
// and out-of-window addresses.
module apb_reg_decode
   import apb_reg_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                NUM_REGS  = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                IDX_W     = idx_w(NUM_REGS)
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  idx,
   output logic              err
);

   localparam int BYTES = DATA_W / 8;
   localparam longint SPAN = longint'(NUM_REGS) * BYTES;

   logic [63:0] off;

   always_comb begin
      off = 64'(addr - BASE_ADDR);
      idx = IDX_W'(off / 64'(BYTES));
      err = (addr < BASE_ADDR)
         || (off % 64'(BYTES) != 64'd0)
         || (off >= 64'(SPAN));
   end

endmodule

// File: rtl/apb_reg_bank.sv
// APB register bank with configurable wait states.
// Define APB_REG_BANK_PSTRB_EN for byte-strobed writes.
module apb_reg_bank
   import apb_reg_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                NUM_REGS    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                WAIT_CYCLES = 0,
   parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
   input  logic                       pclk,
   input  logic                       presetn,
   apb_reg_bank_if.slave              bus,
   output logic [NUM_REGS*DATA_W-1:0] reg_q
);

   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = idx_w(NUM_REGS);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [DATA_W-1:0] wdata_q;
`ifdef APB_REG_BANK_PSTRB_EN
   logic [BYTES-1:0]  strb_q;
`endif
   logic [IDX_W-1:0]  idx;
   logic              dec_err;
   logic              err;
   logic              capture;
   logic              do_wr;
   logic [DATA_W-1:0] wmask;
   logic [DATA_W-1:0] regs [NUM_REGS];

   apb_reg_decode #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BASE_ADDR),
      .IDX_W     (IDX_W)
   ) u_decode (
      .addr (addr_q),
      .idx  (idx),
      .err  (dec_err)
   );

   // DONE accepts a new setup exactly like IDLE
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      capture    = 1'b0;
      bus.pready = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.psel && !bus.penable) begin
               capture = 1'b1;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!bus.psel) begin
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (bus.penable) begin
               bus.pready = 1'b1;
               state_d    = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (capture) begin
         addr_q  <= bus.paddr;
         wr_q    <= bus.pwrite;
         wdata_q <= bus.pwdata;
`ifdef APB_REG_BANK_PSTRB_EN
         strb_q  <= bus.pstrb;
`endif
      end
   end

`ifdef APB_REG_BANK_PSTRB_EN
   assign err = dec_err || (!wr_q && strb_q != '0);

   always_comb begin
      wmask = '0;
      for (int b = 0; b < BYTES; b++)
         wmask[b*8 +: 8] = {8{strb_q[b]}};
   end
`else
   assign err   = dec_err;
   assign wmask = '1;
`endif

   assign do_wr       = bus.pready && wr_q && !err;
   assign bus.pslverr = bus.pready && err;
   assign bus.prdata  = (bus.pready && !wr_q && !err)
                      ? regs[idx] : '0;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      logic [DATA_W-1:0] q;

      always_ff @(posedge pclk) begin
         if (!presetn)
            q <= RESET_VAL;
         else if (do_wr && idx == IDX_W'(g))
            q <= (q & ~wmask) | (wdata_q & wmask);
      end

      assign regs[g] = q;
      assign reg_q[g*DATA_W +: DATA_W] = q;
   end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Randomized bench for apb_reg_bank: three instances with
// 0, 3 and 5 wait states against an array reference model.
module tb_apb_reg_bank;

   localparam int NR = 8;

   logic pclk = 1'b0;
   logic presetn;
   always #5 pclk = ~pclk;

   logic        t_psel, t_penable, t_pwrite;
   logic [31:0] t_paddr, t_pwdata;
   logic [3:0]  t_pstrb;
   int          sel;
   int          wt [3] = '{0, 3, 5};

   apb_reg_bank_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
   apb_reg_bank_if #(.ADDR_W(32), .DATA_W(32)) if3 ();
   apb_reg_bank_if #(.ADDR_W(32), .DATA_W(32)) if5 ();

   assign if0.psel = t_psel && sel == 0;
   assign if3.psel = t_psel && sel == 1;
   assign if5.psel = t_psel && sel == 2;
   assign if0.penable = t_penable;
   assign if3.penable = t_penable;
   assign if5.penable = t_penable;
   assign if0.pwrite = t_pwrite;
   assign if3.pwrite = t_pwrite;
   assign if5.pwrite = t_pwrite;
   assign if0.paddr = t_paddr;
   assign if3.paddr = t_paddr;
   assign if5.paddr = t_paddr;
   assign if0.pwdata = t_pwdata;
   assign if3.pwdata = t_pwdata;
   assign if5.pwdata = t_pwdata;
`ifdef APB_REG_BANK_PSTRB_EN
   assign if0.pstrb = t_pstrb;
   assign if3.pstrb = t_pstrb;
   assign if5.pstrb = t_pstrb;
`endif

   logic [NR*32-1:0] rq0, rq3, rq5;

   apb_reg_bank #(.WAIT_CYCLES(0)) u_dut0 (
      .pclk(pclk), .presetn(presetn), .bus(if0), .reg_q(rq0));
   apb_reg_bank #(.WAIT_CYCLES(3)) u_dut3 (
      .pclk(pclk), .presetn(presetn), .bus(if3), .reg_q(rq3));
   apb_reg_bank #(.WAIT_CYCLES(5)) u_dut5 (
      .pclk(pclk), .presetn(presetn), .bus(if5), .reg_q(rq5));

   logic             o_rdy, o_err;
   logic [31:0]      o_rdata;
   logic [NR*32-1:0] o_rq;

   always_comb begin
      o_rdy = if0.pready; o_err = if0.pslverr;
      o_rdata = if0.prdata; o_rq = rq0;
      if (sel == 1) begin
         o_rdy = if3.pready; o_err = if3.pslverr;
         o_rdata = if3.prdata; o_rq = rq3;
      end else if (sel == 2) begin
         o_rdy = if5.pready; o_err = if5.pslverr;
         o_rdata = if5.prdata; o_rq = rq5;
      end
   end

   logic [31:0] mdl [3][NR];
   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [63:0] got,
                      logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_regs(string tag);
      for (int i = 0; i < NR; i++)
         chk($sformatf("%s reg_q[%0d] dut%0d", tag, i, sel),
             o_rq[i*32 +: 32], mdl[sel][i]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < NR; i++)
            mdl[k][i] = 32'h0;
   endtask

   // Entered and left just after a rising edge.
   task automatic xfer(input bit wr, input logic [31:0] addr,
                       input logic [31:0] data,
                       input logic [3:0] strb, input bit b2b,
                       output logic [31:0] rd);
      bit bad;
      int idx, cyc;
      logic [31:0] m;
      t_psel = 1; t_penable = 0; t_pwrite = wr;
      t_paddr = addr; t_pwdata = data; t_pstrb = strb;
      @(posedge pclk); #1;
      t_penable = 1;
      t_paddr = $urandom; t_pwdata = $urandom;
      t_pwrite = 1'($urandom_range(0, 1));
      t_pstrb = 4'($urandom);
      cyc = 0;
      forever begin
         @(negedge pclk);
         cyc++;
         if (o_rdy) break;
         chk("prdata outside pready", o_rdata, 0);
         chk("pslverr outside pready", o_err, 0);
         if (cyc > 40) begin
            chk("pready timeout", cyc, wt[sel] + 1);
            break;
         end
         @(posedge pclk); #1;
      end
      bad = (addr % 4 != 0) || (addr >= NR * 4);
`ifdef APB_REG_BANK_PSTRB_EN
      if (!wr && strb != 0) bad = 1;
`endif
      idx = bad ? 0 : int'(addr / 4);
      rd = o_rdata;
      chk($sformatf("latency dut%0d", sel), cyc, wt[sel] + 1);
      chk("pslverr", o_err, bad);
      chk("prdata", o_rdata, (wr || bad) ? 0 : mdl[sel][idx]);
      chk("reg_q before edge", o_rq[idx*32 +: 32], mdl[sel][idx]);
      if (wr && !bad) begin
         m = 32'hFFFF_FFFF;
`ifdef APB_REG_BANK_PSTRB_EN
         for (int b = 0; b < 4; b++)
            if (!strb[b]) m[b*8 +: 8] = 8'h00;
`endif
         mdl[sel][idx] = (mdl[sel][idx] & ~m) | (data & m);
      end
      @(posedge pclk); #1;
      if (!b2b) begin t_psel = 0; t_penable = 0; end
      chk("reg_q after edge", o_rq[idx*32 +: 32], mdl[sel][idx]);
   endtask

   logic [31:0] rd;
   logic [31:0] a, d;
   logic [3:0]  s;
   bit          w;
   int          r;

   initial begin
      presetn = 0; sel = 0;
      t_psel = 0; t_penable = 0; t_pwrite = 0;
      t_paddr = 0; t_pwdata = 0; t_pstrb = 0;
      model_reset();
      repeat (2) @(posedge pclk);
      #1 presetn = 1;
      for (int k = 0; k < 3; k++) begin
         sel = k; #1;
         chk("reset pready", o_rdy, 0);
         chk("reset pslverr", o_err, 0);
         chk("reset prdata", o_rdata, 0);
         check_regs("reset");
      end
      @(posedge pclk); #1;

      sel = 0;
      xfer(0, 32'h0C, 0, 4'h0, 0, rd);
      chk("reg3 read after reset", rd, 32'h0);
      xfer(1, 32'h08, 32'hDEADBEEF, 4'hF, 1, rd);
      xfer(0, 32'h08, 0, 4'h0, 0, rd);
      chk("b2b read 0x08", rd, 32'hDEADBEEF);
      chk("reg_q[2]", o_rq[2*32 +: 32], 32'hDEADBEEF);

      sel = 1;
      xfer(1, 32'h00, 32'h0000_1234, 4'hF, 0, rd);
      chk("w3 reg_q[0]", o_rq[31:0], 32'h0000_1234);

      sel = 0;
      xfer(0, 32'h20, 0, 4'h0, 0, rd);
      xfer(0, 32'h02, 0, 4'h0, 0, rd);
      xfer(1, 32'h20, 32'hBAD0BAD0, 4'hF, 0, rd);
      xfer(1, 32'h05, 32'hBAD1BAD1, 4'hF, 0, rd);
      check_regs("after errors");

`ifdef APB_REG_BANK_PSTRB_EN
      xfer(1, 32'h04, 32'h11223344, 4'hF, 0, rd);
      xfer(1, 32'h04, 32'hAABBCCDD, 4'b0101, 0, rd);
      chk("strobed reg1", o_rq[63:32], 32'h11BB33DD);
      xfer(0, 32'h04, 0, 4'b0010, 0, rd);
`endif

      // psel withdrawn in the second access cycle
      sel = 2;
      xfer(1, 32'h14, 32'h5555AAAA, 4'hF, 0, rd);
      t_psel = 1; t_penable = 0; t_pwrite = 1;
      t_paddr = 32'h14; t_pwdata = 32'h0BAD0BAD; t_pstrb = 4'hF;
      @(posedge pclk); #1 t_penable = 1;
      @(negedge pclk);
      chk("abort pready 1st", o_rdy, 0);
      @(posedge pclk); #1 t_psel = 0; t_penable = 0;
      repeat (8) begin
         @(negedge pclk);
         chk("abort pready", o_rdy, 0);
      end
      check_regs("after abort");
      @(posedge pclk); #1;
      xfer(0, 32'h14, 0, 4'h0, 0, rd);
      chk("read after abort", rd, 32'h5555AAAA);

      // reset during a write; held psel/penable must be ignored
      t_psel = 1; t_penable = 0; t_pwrite = 1;
      t_paddr = 32'h0C; t_pwdata = 32'h600DF00D; t_pstrb = 4'hF;
      @(posedge pclk); #1 t_penable = 1;
      @(posedge pclk); #1 presetn = 0;
      @(posedge pclk); #1 presetn = 1;
      model_reset();
      repeat (10) begin
         @(negedge pclk);
         chk("reset abort pready", o_rdy, 0);
         chk("reset abort reg3", o_rq[3*32 +: 32], 32'h0);
      end
      @(posedge pclk); #1 t_psel = 0; t_penable = 0;
      for (int k = 0; k < 3; k++) begin
         sel = k; #1;
         check_regs("after mid reset");
      end
      @(posedge pclk); #1;

      for (int n = 0; n < 80; n++) begin
         sel = $urandom_range(0, 2);
         w = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 19);
         if (r < 16) a = 32'((r % NR) * 4);
         else if (r < 18) a = 32'(NR * 4 + (r - 16) * 4);
         else a = 32'((r % NR) * 4 + $urandom_range(1, 3));
         d = $urandom;
         s = 4'hF;
`ifdef APB_REG_BANK_PSTRB_EN
         if (w) s = 4'($urandom);
         else s = ($urandom_range(0, 5) == 0) ? 4'h1 : 4'h0;
`endif
         xfer(w, a, d, s, 1'($urandom_range(0, 1)), rd);
      end
      t_psel = 0; t_penable = 0;
      for (int k = 0; k < 3; k++) begin
         sel = k; #1;
         check_regs("final");
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/apb_reg_bank.md
APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and APB data width, a multiple of 8 in the range 8..64.
REQ-002 SHALL have parameter ADDR_W, default 32: width of paddr.
REQ-003 SHALL have parameter NUM_REGS, default 8: number of registers, 1..64.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of register 0.
REQ-005 SHALL have parameter WAIT_CYCLES, default 0: access-phase wait states inserted before pready, 0..15.
REQ-006 SHALL have parameter RESET_VAL, default 0: reset value of every register.
REQ-007 SHALL have pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have presetn, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have psel, input, 1 bit: slave select.
REQ-010 SHALL have penable, input, 1 bit: access-phase indicator.
REQ-011 SHALL have pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-012 SHALL have paddr, input, ADDR_W bits: byte address.
REQ-013 SHALL have pwdata, input, DATA_W bits: write data.
REQ-014 SHALL have pstrb, input, DATA_W/8 bits: byte write strobes, present only under APB_REG_BANK_PSTRB_EN.
REQ-015 SHALL have prdata, output, DATA_W bits: read data.
REQ-016 SHALL have pready, output, 1 bit: transfer complete.
REQ-017 SHALL have pslverr, output, 1 bit: transfer error, valid only while pready=1.
REQ-018 SHALL have reg_q, output, NUM_REGS*DATA_W bits: flattened register contents, with register i in bits [i*DATA_W +: DATA_W].

Function
REQ-019 SHALL map register i at byte address BASE_ADDR + i*(DATA_W/8).
REQ-020 SHALL implement the states IDLE, ACCESS and DONE.
REQ-021 IDLE SHALL, on psel=1 and penable=0, capture paddr/pwrite/pwdata (and pstrb), load wait counter with WAIT_CYCLES, and go to ACCESS.
REQ-022 ACCESS SHALL, while counter!=0, decrement it with pready=0; when counter==0 and penable=1, pready SHALL be 1 combinationally from state, and the FSM SHALL go to DONE.
REQ-023 pready SHALL therefore be high exactly one cycle, WAIT_CYCLES+1 cycles after the setup cycle (W=0: first access cycle).
REQ-024 A write SHALL update the addressed register at the clock edge that ends the pready=1 cycle; reg_q SHALL show the new value from the next cycle.
REQ-025 Read prdata SHALL equal the addressed register during the pready=1 cycle and SHALL be 0 in all other cycles.
REQ-026 DONE SHALL return to IDLE in one cycle; a setup sampled in DONE SHALL be handled as if in IDLE, so back-to-back transfers lose no cycle.
REQ-027 An address that is misaligned, below BASE_ADDR, or at/above register NUM_REGS SHALL give pslverr=1 with pready, no register change, and prdata=0.
REQ-028 If psel drops in ACCESS before pready, the FSM SHALL go to IDLE with no write and no pready (abort).
REQ-029 paddr, pwdata and pwrite changes after the setup cycle SHALL be ignored; the captured values SHALL be used.
REQ-030 penable=1 seen in IDLE without a prior setup SHALL be ignored.

Reset
REQ-031 With presetn=0 at a rising edge: state=IDLE, counter=0, every register=RESET_VAL, prdata=0, pready=0, pslverr=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no write, and pready SHALL be low from the next cycle.

Configuration
REQ-033 With APB_REG_BANK_PSTRB_EN defined, a write SHALL update only the bytes whose pstrb bit is 1; a read with pstrb!=0 SHALL give pslverr=1.
REQ-034 Without APB_REG_BANK_PSTRB_EN, there SHALL be no pstrb port and every write SHALL be full-word.

Structure
REQ-035 A shared package apb_reg_pkg SHALL hold the FSM state enum and the WAIT_CYCLES and NUM_REGS limit constants.
REQ-036 Address decode plus error check SHALL be one sub-module, apb_reg_decode: paddr in, index and error flag out, combinational.

Verification
REQ-037 Reset, then read of reg 3 -> pready=1 in first access cycle, prdata=0, pslverr=0.
REQ-038 W=0: write 0xDEADBEEF to 0x08, then back-to-back read 0x08 -> prdata=0xDEADBEEF, reg_q[2]=0xDEADBEEF, no idle cycle between transfers.
REQ-039 W=3: write 0x0000_1234 to 0x00 -> pready low for 3 access cycles, high on the 4th, reg_q[0] updated the cycle after.
REQ-040 Read 0x20 (NUM_REGS=8) and 0x02 -> pslverr=1, prdata=0, no register change.
REQ-041 PSTRB_EN: reg1=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> reg1=0x11BB33DD.
REQ-042 W=5: psel dropped in the 2nd access cycle, and in a separate run presetn pulsed mid-write -> no register change, no pready.
